// File: rtl/button_click_counter_if.sv
// Press-detector acknowledge and click-event handshake signals for button_click_counter.
// master: the click counter. slave: the press detector plus the event consumer.
interface button_click_counter_if #(
    parameter int unsigned CNT_W = 2
) ();
    logic             wasPressed;
    logic             ackPress;
    logic             eventValid;
    logic [CNT_W-1:0] eventCount;
    logic             eventReady;

    modport master (
        input  wasPressed,
        input  eventReady,
        output ackPress,
        output eventValid,
        output eventCount
    );

    modport slave (
        output wasPressed,
        output eventReady,
        input  ackPress,
        input  eventValid,
        input  eventCount
    );
endinterface

// File: rtl/button_click_counter.sv
// Groups acknowledged button presses that fall inside a gap window into one click event
// and hands the click count to the consumer over a valid/ready handshake.
module button_click_counter #(
    parameter int unsigned GAP_CYCLES = 8,
    parameter int unsigned MAX_CLICKS = 3,
    parameter int unsigned CNT_W      = 2,
    parameter int unsigned TMR_W      = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    button_click_counter_if.master       bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACK  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] EMIT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CLICKS);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GAP_CYCLES - 1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_next;

    logic             ack_q;
    logic             valid_q;
    logic [CNT_W-1:0] event_count_q;

    // State, counters and Moore outputs; outputs are loaded from the next state so
    // they track the state register exactly while still coming straight from flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            count         <= CNT_W'(0);
            timer         <= TMR_W'(0);
            ack_q         <= 1'b0;
            valid_q       <= 1'b0;
            event_count_q <= CNT_W'(0);
        end else begin
            state         <= state_next;
            count         <= count_next;
            timer         <= timer_next;
            ack_q         <= (state_next == ACK);
            valid_q       <= (state_next == EMIT);
            event_count_q <= (state_next == EMIT) ? count_next : CNT_W'(0);
        end
    end

    // Next-state logic; in GAP a press outranks a coinciding timeout.
    always_comb begin
        state_next = state;
        count_next = count;
        timer_next = timer;
        case (state)
            IDLE: begin
                if (bus.wasPressed) begin
                    state_next = ACK;
                    count_next = CNT_W'(1);
                end
            end
            ACK: begin
                if (count == CNT_MAX) begin
                    state_next = EMIT;
                end else begin
                    state_next = GAP;
                    timer_next = TMR_W'(0);
                end
            end
            GAP: begin
                if (bus.wasPressed) begin
                    state_next = ACK;
                    count_next = count + CNT_W'(1);
                    timer_next = TMR_W'(0);
                end else if (timer == TMR_LAST) begin
                    state_next = EMIT;
                end else begin
                    timer_next = timer + TMR_W'(1);
                end
            end
            EMIT: begin
                // A press held during EMIT is left for IDLE to take next cycle.
                if (bus.eventReady) begin
                    state_next = IDLE;
                    count_next = CNT_W'(0);
                end
            end
            default: begin
                state_next = IDLE;
                count_next = CNT_W'(0);
                timer_next = TMR_W'(0);
            end
        endcase
    end

    assign bus.ackPress   = ack_q;
    assign bus.eventValid = valid_q;
    assign bus.eventCount = event_count_q;

endmodule

// File: tb/tb_button_click_counter.sv
// Directed bench for button_click_counter: scoreboard of expected click counts,
// latency, priority, backpressure and asynchronous-reset checks.
module tb_button_click_counter;

    logic clock;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   exp_q[$];

    button_click_counter_if #(.CNT_W(2)) bus ();

    button_click_counter #(
        .GAP_CYCLES(8),
        .MAX_CLICKS(3),
        .CNT_W     (2),
        .TMR_W     (3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Wait (bounded) for ackPress, drop the press, confirm the pulse is one cycle long.
    task automatic take_press(input string tag, output int at);
        int n = 0;
        while (!bus.ackPress && n < 40) begin
            step();
            n++;
        end
        at = cyc;
        check({tag, "_ack"}, 32'(bus.ackPress), 32'd1);
        bus.wasPressed = 1'b0;
        step();
        check({tag, "_ack_pulse"}, 32'(bus.ackPress), 32'd0);
    endtask

    // Wait (bounded) for eventValid, then compare latency and count against the scoreboard.
    task automatic take_event(input string tag, input int ack_at, input int lat);
        int n = 0;
        int e;
        while (!bus.eventValid && n < 40) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 32'(bus.eventValid), 32'd1);
        check({tag, "_latency"}, 32'(cyc - ack_at), 32'(lat));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check({tag, "_count"}, 32'(bus.eventCount), 32'(e));
    endtask

    initial begin
        int a;
        int seen;

        reset          = 1'b0;
        bus.wasPressed = 1'b0;
        bus.eventReady = 1'b1;
        #2;
        check("rst_ack", 32'(bus.ackPress), 32'd0);
        check("rst_valid", 32'(bus.eventValid), 32'd0);
        check("rst_count", 32'(bus.eventCount), 32'd0);
        step();
        step();
        reset = 1'b1;
        step();

        // Single press: event 9 edges after the ack edge, shown for one cycle.
        bus.wasPressed = 1'b1;
        exp_q.push_back(1);
        take_press("single", a);
        take_event("single", a, 9);
        step();
        check("single_valid_drop", 32'(bus.eventValid), 32'd0);
        check("single_count_drop", 32'(bus.eventCount), 32'd0);

        // Double press: second press 4 cycles into GAP.
        step();
        bus.wasPressed = 1'b1;
        exp_q.push_back(2);
        take_press("dbl1", a);
        repeat (3) step();
        bus.wasPressed = 1'b1;
        take_press("dbl2", a);
        take_event("dbl", a, 9);
        step();

        // Max clicks: third press closes the group on the very next edge.
        bus.wasPressed = 1'b1;
        exp_q.push_back(3);
        take_press("max1", a);
        step();
        bus.wasPressed = 1'b1;
        take_press("max2", a);
        step();
        bus.wasPressed = 1'b1;
        take_press("max3", a);
        take_event("max", a, 1);
        step();

        // Press seen with timer at its last value wins over the timeout.
        bus.wasPressed = 1'b1;
        exp_q.push_back(2);
        take_press("prio1", a);
        repeat (7) step();
        bus.wasPressed = 1'b1;
        step();
        check("prio_ack", 32'(bus.ackPress), 32'd1);
        check("prio_no_emit", 32'(bus.eventValid), 32'd0);
        take_press("prio2", a);
        take_event("prio", a, 9);
        step();

        // Backpressure with a held press: event stable, press not acknowledged.
        bus.wasPressed = 1'b1;
        exp_q.push_back(1);
        take_press("bp", a);
        bus.eventReady = 1'b0;
        take_event("bp", a, 9);
        bus.wasPressed = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_valid", 32'(bus.eventValid), 32'd1);
            check("bp_hold_count", 32'(bus.eventCount), 32'd1);
            check("bp_hold_noack", 32'(bus.ackPress), 32'd0);
        end
        bus.eventReady = 1'b1;
        step();
        check("bp_release_valid", 32'(bus.eventValid), 32'd0);
        check("bp_release_noack", 32'(bus.ackPress), 32'd0);
        step();
        check("bp_next_ack", 32'(bus.ackPress), 32'd1);
        exp_q.push_back(1);
        take_press("bp2", a);
        take_event("bp2", a, 9);
        step();

        // Reset during ACK with the press still held: ack drops at once, press retaken.
        bus.wasPressed = 1'b1;
        step();
        check("rack_ack_before", 32'(bus.ackPress), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rack_ack_async", 32'(bus.ackPress), 32'd0);
        step();
        reset = 1'b1;
        step();
        check("rack_retake", 32'(bus.ackPress), 32'd1);
        bus.wasPressed = 1'b0;

        // Reset 3 cycles into GAP: everything clears and no event follows.
        repeat (4) step();
        #2;
        reset = 1'b0;
        #1;
        check("rgap_ack", 32'(bus.ackPress), 32'd0);
        check("rgap_valid", 32'(bus.eventValid), 32'd0);
        check("rgap_count", 32'(bus.eventCount), 32'd0);
        step();
        reset = 1'b1;
        seen = 0;
        repeat (20) begin
            step();
            if (bus.eventValid) seen++;
        end
        check("rgap_no_event", 32'(seen), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_click_counter.md
Name: button_click_counter

Overview:
- Sits directly downstream of the button press detector. Consumes its `wasPressed` level and returns its `ackPress` acknowledge.
- Groups presses that arrive within a programmable gap window into one click event: single, double or up to MAX_CLICKS.
- Presents the click count to the consumer over a valid/ready handshake.

Parameters:
- GAP_CYCLES, 8, cycles to wait after an acknowledged press for a further press before the group closes. Must be ≥ 2; use a large value in hardware (e.g. 12_500_000).
- MAX_CLICKS, 3, group size that closes the group immediately without waiting for the gap. Must be ≥ 1.
- CNT_W, 2, width of eventCount. Must satisfy 2^CNT_W > MAX_CLICKS.
- TMR_W, 3, width of the gap timer. Must satisfy 2^TMR_W ≥ GAP_CYCLES.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- wasPressed  in  1  from the detector; held high until acknowledged.
- ackPress  out  1  to the detector; one-cycle registered acknowledge.
- eventValid  out  1  click event available.
- eventCount  out  CNT_W  number of clicks in the group; valid while eventValid = 1.
- eventReady  in  1  consumer accepts the event.

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE, count = 0, timer = 0, ackPress = 0, eventValid = 0, eventCount = 0.
- All outputs are registered Moore outputs:
  - ackPress = (state == ACK).
  - eventValid = (state == EMIT).
  - eventCount = count while in EMIT, otherwise 0.
- IDLE:
  - wasPressed = 1 → ACK, count = 1.
  - Otherwise stay in IDLE.
- ACK (exactly one cycle):
  - count == MAX_CLICKS → EMIT.
  - Otherwise → GAP, timer = 0.
- GAP (checked in priority order each cycle):
  1. wasPressed = 1 → ACK, count = count + 1, timer = 0.
  2. timer == GAP_CYCLES-1 → EMIT.
  3. Otherwise timer = timer + 1.
  - A press and a timeout in the same cycle count the press; the press wins.
- EMIT:
  - eventValid = 1 with eventCount stable until accepted.
  - eventReady = 1 → IDLE, count = 0.
  - Presses arriving during EMIT are not acknowledged. The detector keeps wasPressed high, and the press is taken in the cycle after the return to IDLE. This holds even when eventReady and wasPressed are both 1 in the same cycle.
- Acknowledge timing:
  - After ACK, the detector drops wasPressed on the same edge that moves this block to GAP.
  - The block must never acknowledge a single press twice.
  - ackPress never stays high for two consecutive cycles.
- Latency:
  - IDLE seeing wasPressed at edge k puts ackPress high for cycle k..k+1.
  - A single press gives eventValid = 1 at edge k+1+GAP_CYCLES.
- count never exceeds MAX_CLICKS; the immediate EMIT enforces this.
- Reset asserted mid-group (ACK, GAP or EMIT):
  - Returns to IDLE at once and the partial group is discarded.
  - Any press the detector still holds is taken after reset releases.

Test Plan (GAP_CYCLES = 8, MAX_CLICKS = 3, eventReady = 1 unless stated):
- Single press: wasPressed high until ack at edge k → ackPress high for exactly one cycle; eventValid = 1 with eventCount = 1 at edge k+9, held for one cycle; then IDLE.
- Double press: second wasPressed arrives 4 cycles into GAP → second ackPress pulse; eventValid fires 9 edges after the second ACK with eventCount = 2.
- Max clicks: three presses, each 2 cycles into GAP → after the third ACK, eventValid = 1 on the next edge with eventCount = 3, with no gap wait.
- Boundary priority: a press first seen when timer = 7 → ACK taken, no EMIT that cycle; group eventually reports eventCount = 2.
- Backpressure: eventReady = 0 for 5 cycles in EMIT with wasPressed high → eventValid and eventCount = 1 stable and ackPress = 0 throughout. Raise eventReady → IDLE, then ACK on the next edge; the new group later reports eventCount = 1.
- Reset mid-GAP: reset pulled low 3 cycles into GAP → ackPress, eventValid and eventCount all 0 immediately, without waiting for a clock edge; no event is emitted after release.
